// File: rtl/keyboard_key_decoder_if.sv
// keyboard_key_decoder_if: PS/2 byte stream in, held-key levels out.
interface keyboard_key_decoder_if;
   logic [7:0] rx_data;
   logic rx_valid;
   logic rx_error;
   logic key_space;
   logic key_left;
   logic key_right;
   logic key_event;
   modport master (output rx_data, rx_valid, rx_error, input key_space, key_left, key_right, key_event);
   modport slave (input rx_data, rx_valid, rx_error, output key_space, key_left, key_right, key_event);
endinterface

// File: rtl/keyboard_key_decoder.sv
// keyboard_key_decoder: scan-code set 2 make/break decoder producing held space/left/right levels.
module keyboard_key_decoder #(
   parameter int TIMEOUT_CYCLES = 80000,
   parameter bit ENABLE_WASD = 1
) (
   input logic clk,
   input logic rst,
   keyboard_key_decoder_if.slave kb
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic sp_held, w_held, larrow_held, a_held, rarrow_held, d_held;
   logic sp_n, w_n, larrow_n, a_n, rarrow_n, d_n, ks_n, kl_n, kr_n;
   logic fire, mk, bk, em, eb;
   logic is_sp, is_w, is_a, is_d, is_l, is_r;
   assign fire = kb.rx_valid & ~kb.rx_error;
   assign mk = fire && state == IDLE;
   assign bk = fire && state == BRK;
   assign em = fire && state == EXT;
   assign eb = fire && state == EXT_BRK;
   assign is_sp = kb.rx_data == 8'h29;
   assign is_w = ENABLE_WASD && kb.rx_data == 8'h1D;
   assign is_a = ENABLE_WASD && kb.rx_data == 8'h1C;
   assign is_d = ENABLE_WASD && kb.rx_data == 8'h23;
   assign is_l = kb.rx_data == 8'h6B;
   assign is_r = kb.rx_data == 8'h74;
   // Plain codes only act from IDLE/BRK, arrows only from EXT/EXT_BRK.
   assign sp_n = (sp_held | (mk & is_sp)) & ~(bk & is_sp);
   assign w_n = (w_held | (mk & is_w)) & ~(bk & is_w);
   assign a_n = (a_held | (mk & is_a)) & ~(bk & is_a);
   assign d_n = (d_held | (mk & is_d)) & ~(bk & is_d);
   assign larrow_n = (larrow_held | (em & is_l)) & ~(eb & is_l);
   assign rarrow_n = (rarrow_held | (em & is_r)) & ~(eb & is_r);
   assign ks_n = sp_n | w_n;
   assign kl_n = larrow_n | a_n;
   assign kr_n = rarrow_n | d_n;
   always_comb begin
      state_n = state;
      if (kb.rx_error)
         state_n = IDLE;
      else if (kb.rx_valid)
         state_n = (state == IDLE && kb.rx_data == 8'hE0) ? EXT :
                   (state == IDLE && kb.rx_data == 8'hF0) ? BRK :
                   (state == EXT && kb.rx_data == 8'hF0) ? EXT_BRK : IDLE;
      else if (state != IDLE && cnt == TMAX)
         state_n = IDLE;
      cnt_n = (kb.rx_valid || kb.rx_error || state == IDLE) ? '0 : (cnt == TMAX) ? cnt : cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         {sp_held, w_held, larrow_held, a_held, rarrow_held, d_held} <= '0;
         {kb.key_space, kb.key_left, kb.key_right, kb.key_event} <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         {sp_held, w_held, larrow_held, a_held, rarrow_held, d_held} <= {sp_n, w_n, larrow_n, a_n, rarrow_n, d_n};
         {kb.key_space, kb.key_left, kb.key_right} <= {ks_n, kl_n, kr_n};
         kb.key_event <= {ks_n, kl_n, kr_n} != {kb.key_space, kb.key_left, kb.key_right};
      end
   end
endmodule

// File: tb/tb_keyboard_key_decoder.sv
// tb_keyboard_key_decoder: directed scan-code sequences on a WASD and a non-WASD decoder, scoreboard-checked.
module tb_keyboard_key_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int step_no = 0;
   logic [7:0] sb[$];
   keyboard_key_decoder_if kb_a ();
   keyboard_key_decoder_if kb_b ();
   keyboard_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(1)) dut_a (.clk(clk), .rst(rst), .kb(kb_a.slave));
   keyboard_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(0)) dut_b (.clk(clk), .rst(rst), .kb(kb_b.slave));
   always #5 clk = ~clk;
   // Expected values are {space, left, right, event} after the edge that samples the stimulus.
   task automatic step(input logic r, input logic [7:0] d, input logic v, input logic e,
                       input logic [3:0] ea, input logic [3:0] eb);
      logic [7:0] exp;
      logic [3:0] obs_a, obs_b;
      @(negedge clk);
      rst = r;
      kb_a.rx_data = d; kb_a.rx_valid = v; kb_a.rx_error = e;
      kb_b.rx_data = d; kb_b.rx_valid = v; kb_b.rx_error = e;
      sb.push_back({ea, eb});
      @(posedge clk);
      #1;
      rst = 1'b0;
      kb_a.rx_valid = 1'b0; kb_a.rx_error = 1'b0;
      kb_b.rx_valid = 1'b0; kb_b.rx_error = 1'b0;
      exp = sb.pop_front();
      step_no++;
      obs_a = {kb_a.key_space, kb_a.key_left, kb_a.key_right, kb_a.key_event};
      obs_b = {kb_b.key_space, kb_b.key_left, kb_b.key_right, kb_b.key_event};
      checks++;
      assert (obs_a === exp[7:4]) else begin
         errors++;
         $error("FAIL wasd1 step %0d observed %b expected %b", step_no, obs_a, exp[7:4]);
      end
      checks++;
      assert (obs_b === exp[3:0]) else begin
         errors++;
         $error("FAIL wasd0 step %0d observed %b expected %b", step_no, obs_b, exp[3:0]);
      end
   endtask
   task automatic tx(input logic [7:0] d, input logic [3:0] ea, input logic [3:0] eb);
      step(1'b0, d, 1'b1, 1'b0, ea, eb);
   endtask
   task automatic txe(input logic [7:0] d, input logic [3:0] ea, input logic [3:0] eb);
      step(1'b0, d, 1'b1, 1'b1, ea, eb);
   endtask
   task automatic nop(input logic [3:0] ea, input logic [3:0] eb);
      step(1'b0, 8'h00, 1'b0, 1'b0, ea, eb);
   endtask
   task automatic rst_cyc(input logic [3:0] ea, input logic [3:0] eb);
      step(1'b1, 8'h00, 1'b0, 1'b0, ea, eb);
   endtask
   initial begin
      kb_a.rx_data = 8'h00; kb_a.rx_valid = 1'b0; kb_a.rx_error = 1'b0;
      kb_b.rx_data = 8'h00; kb_b.rx_valid = 1'b0; kb_b.rx_error = 1'b0;
      rst_cyc(4'b0000, 4'b0000);
      rst_cyc(4'b0000, 4'b0000);
      nop(4'b0000, 4'b0000);
      // space make then break
      tx(8'h29, 4'b1001, 4'b1001);
      nop(4'b1000, 4'b1000);
      tx(8'hF0, 4'b1000, 4'b1000);
      tx(8'h29, 4'b0001, 4'b0001);
      nop(4'b0000, 4'b0000);
      // both arrows, release left, then right
      tx(8'hE0, 4'b0000, 4'b0000);
      tx(8'h6B, 4'b0101, 4'b0101);
      tx(8'hE0, 4'b0100, 4'b0100);
      tx(8'h74, 4'b0111, 4'b0111);
      tx(8'hE0, 4'b0110, 4'b0110);
      tx(8'hF0, 4'b0110, 4'b0110);
      tx(8'h6B, 4'b0011, 4'b0011);
      nop(4'b0010, 4'b0010);
      tx(8'hE0, 4'b0010, 4'b0010);
      tx(8'hF0, 4'b0010, 4'b0010);
      tx(8'h74, 4'b0001, 4'b0001);
      nop(4'b0000, 4'b0000);
      // A held across an arrow press/release; WASD-disabled instance ignores A
      tx(8'h1C, 4'b0101, 4'b0000);
      tx(8'hE0, 4'b0100, 4'b0000);
      tx(8'h6B, 4'b0100, 4'b0101);
      tx(8'hE0, 4'b0100, 4'b0100);
      tx(8'hF0, 4'b0100, 4'b0100);
      tx(8'h6B, 4'b0100, 4'b0001);
      tx(8'hF0, 4'b0100, 4'b0000);
      tx(8'h1C, 4'b0001, 4'b0000);
      nop(4'b0000, 4'b0000);
      // D and W make/break
      tx(8'h23, 4'b0011, 4'b0000);
      tx(8'h1D, 4'b1011, 4'b0000);
      tx(8'hF0, 4'b1010, 4'b0000);
      tx(8'h23, 4'b1001, 4'b0000);
      tx(8'hF0, 4'b1000, 4'b0000);
      tx(8'h1D, 4'b0001, 4'b0000);
      nop(4'b0000, 4'b0000);
      // E0 then timeout: 6B afterwards is decoded in IDLE
      tx(8'hE0, 4'b0000, 4'b0000);
      for (int i = 0; i < 18; i++) nop(4'b0000, 4'b0000);
      tx(8'h6B, 4'b0000, 4'b0000);
      nop(4'b0000, 4'b0000);
      // E0 then 6B on the expiry cycle: byte wins, still decoded in EXT
      tx(8'hE0, 4'b0000, 4'b0000);
      for (int i = 0; i < 15; i++) nop(4'b0000, 4'b0000);
      tx(8'h6B, 4'b0101, 4'b0101);
      nop(4'b0100, 4'b0100);
      tx(8'hE0, 4'b0100, 4'b0100);
      tx(8'hF0, 4'b0100, 4'b0100);
      tx(8'h6B, 4'b0001, 4'b0001);
      nop(4'b0000, 4'b0000);
      // typematic repeat and errored bytes
      tx(8'h29, 4'b1001, 4'b1001);
      tx(8'h29, 4'b1000, 4'b1000);
      tx(8'h29, 4'b1000, 4'b1000);
      txe(8'hF0, 4'b1000, 4'b1000);
      tx(8'h29, 4'b1000, 4'b1000);
      tx(8'hE0, 4'b1000, 4'b1000);
      txe(8'hF0, 4'b1000, 4'b1000);
      tx(8'h74, 4'b1000, 4'b1000);
      tx(8'hF0, 4'b1000, 4'b1000);
      tx(8'h29, 4'b0001, 4'b0001);
      nop(4'b0000, 4'b0000);
      // reset mid-sequence clears everything and drops the pending E0
      tx(8'hE0, 4'b0000, 4'b0000);
      tx(8'h74, 4'b0011, 4'b0011);
      nop(4'b0010, 4'b0010);
      tx(8'hE0, 4'b0010, 4'b0010);
      rst_cyc(4'b0000, 4'b0000);
      tx(8'h74, 4'b0000, 4'b0000);
      nop(4'b0000, 4'b0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
